per_slave_id_tracker: RTL and testbench

PER_SLAVE_ID_TRACKER -- requirements
Module: per_slave_id_tracker

---
 rtl/per_interco_pkg.sv | 13 +
 rtl/per_slave_id_tracker_if.sv | 55 +++++
 rtl/per_id_fifo.sv | 65 ++++++
 rtl/per_slave_id_tracker.sv | 149 ++++++++++++++
 tb/tb_per_slave_id_tracker.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/per_interco_pkg.sv
// Shared constants for the peripheral interconnect.
//   opc_e         response opcode encoding (OK / ERR)
//   TMO_RDATA     read data returned on a synthesized timeout error response
package per_interco_pkg;

  typedef enum logic {
    OPC_OK  = 1'b0,
    OPC_ERR = 1'b1
  } opc_e;

  localparam logic [31:0] TMO_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/per_slave_id_tracker_if.sv
// Request/response bus around one peripheral slave.
//   data_*   upstream side (master issues request with one-hot ID, gets response)
//   per_*    peripheral side (slave sees request without ID, returns in order)
// Modports:
//   slave  : the tracker's view (consumes upstream requests, drives peripheral)
//   master : the environment's view (drives upstream, models peripheral)
interface per_slave_id_tracker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 16
);
  // upstream request
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_wen_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_o;
  // upstream response
  logic                  data_r_valid_o;
  logic [ID_WIDTH-1:0]   data_r_ID_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic                  data_r_opc_o;
  // peripheral request
  logic                  per_req_o;
  logic [ADDR_WIDTH-1:0] per_add_o;
  logic                  per_wen_o;
  logic [DATA_WIDTH-1:0] per_wdata_o;
  logic [BE_WIDTH-1:0]   per_be_o;
  logic                  per_gnt_i;
  // peripheral response
  logic                  per_r_valid_i;
  logic [DATA_WIDTH-1:0] per_r_rdata_i;
  logic                  per_r_opc_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o,
    output data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_opc_o,
    output per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o,
    input  per_gnt_i,
    input  per_r_valid_i, per_r_rdata_i, per_r_opc_i
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o,
    input  data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_opc_o,
    input  per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o,
    output per_gnt_i,
    output per_r_valid_i, per_r_rdata_i, per_r_opc_i
  );
endinterface

// File: rtl/per_id_fifo.sv
// In-order ID FIFO, no bypass: a pushed ID is visible at head_o at the
// earliest one cycle after the push.
//   push_i/id_i   write one ID (ignored when full)
//   pop_i         drop head (ignored when empty)
//   head_o        oldest ID (valid when !empty_o)
//   full_o/empty_o/count_o   registered occupancy
module per_id_fifo #(
  parameter int ID_WIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [ID_WIDTH-1:0]       id_i,
  input  logic                      pop_i,
  output logic [ID_WIDTH-1:0]       head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ID_WIDTH-1:0] mem_q;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  // local guards keep count within [0, DEPTH] whatever the caller does
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    wptr_d = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = do_pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage needs no reset: entries are only read while count is nonzero
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= id_i;
  end
endmodule

// File: rtl/per_slave_id_tracker.sv
// Tracks master IDs for a single in-order peripheral slave. The peripheral
// never sees an ID; the tracker queues the one-hot ID of each granted request
// and tags the (registered) response with the oldest queued ID.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   bus (slave)     upstream request/response + peripheral request/response
//   outstanding_o   in-flight request count
//   spurious_o      one-cycle pulse: a peripheral response arrived with nothing queued
// Optional: define PER_TRACKER_TIMEOUT_EN to add parameter TIMEOUT, a per-head
// timeout that returns an error response, and a drop counter that silently
// absorbs the late responses of timed-out requests.
module per_slave_id_tracker
  import per_interco_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH      = 4
`ifdef PER_TRACKER_TIMEOUT_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  per_slave_id_tracker_if.slave  bus,
  output logic [$clog2(DEPTH):0] outstanding_o,
  output logic                   spurious_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                  vld;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  opc;
  } rsp_t;

  rsp_t                rsp_q, rsp_d;
  logic                spur_q, spur_d;
  logic                full, empty, push, pop, rsp_take, spur_hit;
  logic [ID_WIDTH-1:0] head;
  logic [CW-1:0]       cnt;

  // full comes from the registered count, so a pop in the full cycle
  // releases the grant only on the following cycle
  assign bus.per_req_o   = bus.data_req_i & ~full;
  assign bus.data_gnt_o  = bus.per_gnt_i  & ~full;
  assign bus.per_add_o   = ADDR_WIDTH'(bus.data_add_i);
  assign bus.per_wen_o   = bus.data_wen_i;
  assign bus.per_wdata_o = bus.data_wdata_i;
  assign bus.per_be_o    = BE_WIDTH'(bus.data_be_i);

  assign push = bus.data_req_i & bus.data_gnt_o;

`ifdef PER_TRACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = 16;

  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] drop_q, drop_d;
  logic          tmo_fire, dropping;

  // responses owed to already timed-out requests are swallowed first
  assign dropping = (drop_q != '0);
  assign rsp_take = bus.per_r_valid_i & ~empty & ~dropping;
  assign spur_hit = bus.per_r_valid_i &  empty & ~dropping;
  // a real response in the same cycle wins over the timeout
  assign tmo_fire = ~empty & (tmo_q == TW'(TIMEOUT)) & ~rsp_take;
  assign pop      = rsp_take | tmo_fire;

  always_comb begin
    tmo_d  = (pop | empty) ? '0 : tmo_q + TW'(1);
    drop_d = drop_q;
    if (tmo_fire && !(bus.per_r_valid_i && dropping)) begin
      if (drop_q != '1) drop_d = drop_q + DW'(1);
    end else if (!tmo_fire && bus.per_r_valid_i && dropping) begin
      drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q  <= '0;
      drop_q <= '0;
    end else begin
      tmo_q  <= tmo_d;
      drop_q <= drop_d;
    end
  end
`else
  assign rsp_take = bus.per_r_valid_i & ~empty;
  assign spur_hit = bus.per_r_valid_i &  empty;
  assign pop      = rsp_take;
`endif

  per_id_fifo #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .id_i    (bus.data_ID_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  // response register: ID/data/opc hold their last value while vld is low
  always_comb begin
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;
    spur_d    = spur_hit;
    if (rsp_take) begin
      rsp_d.vld   = 1'b1;
      rsp_d.id    = head;
      rsp_d.rdata = bus.per_r_rdata_i;
      rsp_d.opc   = bus.per_r_opc_i;
    end
`ifdef PER_TRACKER_TIMEOUT_EN
    else if (tmo_fire) begin
      rsp_d.vld   = 1'b1;
      rsp_d.id    = head;
      rsp_d.rdata = DATA_WIDTH'(TMO_RDATA);
      rsp_d.opc   = OPC_ERR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      rsp_q  <= rsp_d;
      spur_q <= spur_d;
    end
  end

  assign bus.data_r_valid_o = rsp_q.vld;
  assign bus.data_r_ID_o    = rsp_q.id;
  assign bus.data_r_rdata_o = rsp_q.rdata;
  assign bus.data_r_opc_o   = rsp_q.opc;
  assign outstanding_o      = cnt;
  assign spurious_o         = spur_q;
endmodule

// File: tb/tb_per_slave_id_tracker.sv
// Directed bench for per_slave_id_tracker (DEPTH=4). Inputs change 1ns after
// the rising edge; outputs are checked at that point or just before the next edge.
module tb_per_slave_id_tracker;
  logic       clk;
  logic       rst_n;
  logic [2:0] outstanding;
  logic       spurious;
  int         n_tests = 0;
  int         n_fail  = 0;

  per_slave_id_tracker_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(16)
  ) bus ();

  per_slave_id_tracker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(16), .DEPTH(4)
`ifdef PER_TRACKER_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .outstanding_o (outstanding),
    .spurious_o    (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ord [3];
    logic [15:0] fill_rest [4];
    ord       = '{16'h0001, 16'h0002, 16'h0008};
    fill_rest = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};

    rst_n = 1'b0;
    bus.data_req_i = 0; bus.data_add_i = 0; bus.data_wen_i = 0;
    bus.data_wdata_i = 0; bus.data_be_i = 0; bus.data_ID_i = 0;
    bus.per_gnt_i = 0; bus.per_r_valid_i = 0; bus.per_r_rdata_i = 0; bus.per_r_opc_i = 0;
    #3;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_r_valid", bus.data_r_valid_o, 0);
    chk("rst_r_id", bus.data_r_ID_o, 0);
    chk("rst_r_rdata", bus.data_r_rdata_o, 0);
    chk("rst_r_opc", bus.data_r_opc_o, 0);
    chk("rst_spurious", spurious, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single read, response 3 cycles after the request
    bus.data_req_i = 1; bus.data_ID_i = 16'h0004; bus.data_add_i = 32'h0000_0100;
    bus.data_wen_i = 0; bus.data_wdata_i = 32'h55; bus.data_be_i = 4'hF; bus.per_gnt_i = 1;
    #1;
    chk("single_per_req", bus.per_req_o, 1);
    chk("single_gnt", bus.data_gnt_o, 1);
    chk("single_add", bus.per_add_o, 32'h100);
    chk("single_be", bus.per_be_o, 4'hF);
    tick();
    bus.data_req_i = 0;
    chk("single_outstanding", outstanding, 1);
    tick(); tick();
    bus.per_r_valid_i = 1; bus.per_r_rdata_i = 32'hCAFE0001; bus.per_r_opc_i = 0;
    #1;
    chk("single_no_early_valid", bus.data_r_valid_o, 0);
    tick();
    bus.per_r_valid_i = 0;
    chk("single_r_valid", bus.data_r_valid_o, 1);
    chk("single_r_id", bus.data_r_ID_o, 16'h0004);
    chk("single_r_rdata", bus.data_r_rdata_o, 32'hCAFE0001);
    chk("single_r_opc", bus.data_r_opc_o, 0);
    chk("single_drained", outstanding, 0);
    tick();
    chk("single_valid_drop", bus.data_r_valid_o, 0);
    chk("single_id_hold", bus.data_r_ID_o, 16'h0004);
    chk("single_rdata_hold", bus.data_r_rdata_o, 32'hCAFE0001);

    // fill to DEPTH, 5th request blocked until the cycle after the first pop
    for (int i = 0; i < 4; i++) begin
      bus.data_req_i = 1; bus.data_ID_i = 16'(1 << i);
      tick();
    end
    bus.data_ID_i = 16'h0010;
    #1;
    chk("fill_outstanding", outstanding, 4);
    chk("fill_gnt_blocked", bus.data_gnt_o, 0);
    chk("fill_req_blocked", bus.per_req_o, 0);
    bus.per_r_valid_i = 1; bus.per_r_rdata_i = 32'h11;
    #1;
    chk("fill_gnt_blocked_on_pop", bus.data_gnt_o, 0);
    tick();
    bus.per_r_valid_i = 0;
    #1;
    chk("fill_gnt_released", bus.data_gnt_o, 1);
    chk("fill_req_released", bus.per_req_o, 1);
    chk("fill_first_id", bus.data_r_ID_o, 16'h0001);
    chk("fill_after_pop", outstanding, 3);
    tick();
    bus.data_req_i = 0;
    chk("fill_refilled", outstanding, 4);
    bus.per_r_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fill_drain_id", bus.data_r_ID_o, fill_rest[k]);
    end
    bus.per_r_valid_i = 0;
    chk("fill_empty", outstanding, 0);

    // ordering
    for (int i = 0; i < 3; i++) begin
      bus.data_req_i = 1; bus.data_ID_i = ord[i];
      tick();
    end
    bus.data_req_i = 0;
    bus.per_r_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("order_valid", bus.data_r_valid_o, 1);
      chk("order_id", bus.data_r_ID_o, ord[i]);
    end
    bus.per_r_valid_i = 0;

    // simultaneous push and pop at count 2
    bus.data_req_i = 1; bus.data_ID_i = 16'h0020; tick();
    bus.data_ID_i = 16'h0040; tick();
    bus.data_ID_i = 16'h0080; bus.per_r_valid_i = 1; bus.per_r_rdata_i = 32'h22;
    tick();
    bus.data_req_i = 0;
    chk("simul_count", outstanding, 2);
    chk("simul_id", bus.data_r_ID_o, 16'h0020);
    tick();
    chk("simul_id2", bus.data_r_ID_o, 16'h0040);
    tick();
    bus.per_r_valid_i = 0;
    chk("simul_id3", bus.data_r_ID_o, 16'h0080);
    chk("simul_empty", outstanding, 0);

    // spurious response
    bus.per_r_valid_i = 1; bus.per_r_rdata_i = 32'h33;
    tick();
    bus.per_r_valid_i = 0;
    chk("spur_no_valid", bus.data_r_valid_o, 0);
    chk("spur_pulse", spurious, 1);
    tick();
    chk("spur_one_cycle", spurious, 0);

    // reset with requests in flight
    bus.data_req_i = 1; bus.data_ID_i = 16'h0100; tick();
    bus.data_ID_i = 16'h0200; tick();
    bus.data_req_i = 0;
    chk("midrst_before", outstanding, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", outstanding, 0);
    chk("midrst_r_id", bus.data_r_ID_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.per_r_valid_i = 1;
    tick();
    bus.per_r_valid_i = 0;
    chk("midrst_spur", spurious, 1);
    chk("midrst_no_valid", bus.data_r_valid_o, 0);

`ifdef PER_TRACKER_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      bus.data_req_i = 1; bus.data_ID_i = 16'h0400;
      tick();
      bus.data_req_i = 0;
      while (!bus.data_r_valid_o && waited < 20) begin
        tick();
        waited++;
      end
      chk("tmo_valid", bus.data_r_valid_o, 1);
      chk("tmo_not_early", (waited >= 8), 1);
      chk("tmo_opc", bus.data_r_opc_o, 1);
      chk("tmo_rdata", bus.data_r_rdata_o, 32'hBADACCE5);
      chk("tmo_id", bus.data_r_ID_o, 16'h0400);
      chk("tmo_empty", outstanding, 0);
      bus.per_r_valid_i = 1; bus.per_r_rdata_i = 32'h44;
      tick();
      bus.per_r_valid_i = 0;
      chk("tmo_late_dropped", bus.data_r_valid_o, 0);
      chk("tmo_late_not_spur", spurious, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
